// File: rtl/seq_add_pkg.sv
// Shared encodings for the nibble-serial adder controller.
package seq_add_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1
   } state_e;

endpackage

// File: rtl/add_slice_4.sv
// Purely combinational 4-bit ripple-carry slice shared across all nibble steps.
module add_slice_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] s,
   output logic       c_out
);

   logic [4:0] c;

   assign c[0] = c_in;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign c_out = c[4];

endmodule

// File: rtl/seq_add_ctrl.sv
// Nibble-serial multi-precision adder: one 4-bit slice stepped LSB-first over WIDTH bits.
// Optional subtract/overflow support is enabled by defining SEQ_ADD_SUB_EN.
module seq_add_ctrl
   import seq_add_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef SEQ_ADD_SUB_EN
   input  logic             sub,
   output logic             ovf,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("seq_add_ctrl: WIDTH must be a positive multiple of 4");
   end

   state_e                 state_q;
   logic [IDX_W-1:0]       idx_q;
   logic [WIDTH-1:0]       a_q, b_q;
   logic                   carry_q;
   logic [WIDTH-1:0]       work_q, work_d;
   logic                   busy_q, done_q, cout_q;
   logic [WIDTH-1:0]       sum_q;

   logic [NIBBLE_W-1:0]    a_nib, b_nib, s_nib;
   logic                   s_cout;

   assign a_nib = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
   assign b_nib = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

   add_slice_4 u_slice (
      .a     (a_nib),
      .b     (b_nib),
      .c_in  (carry_q),
      .s     (s_nib),
      .c_out (s_cout)
   );

   always_comb begin
      work_d = work_q;
      work_d[idx_q*NIBBLE_W +: NIBBLE_W] = s_nib;
   end

`ifdef SEQ_ADD_SUB_EN
   logic ovf_q;
   logic c_top;
   // Carry into the MSB recovered from the top bit's sum: s = a ^ b ^ cin.
   assign c_top = a_nib[NIBBLE_W-1] ^ b_nib[NIBBLE_W-1] ^ s_nib[NIBBLE_W-1];
   assign ovf   = ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         work_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SEQ_ADD_SUB_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_q     <= a;
`ifdef SEQ_ADD_SUB_EN
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : c_in;
`else
                  b_q     <= b;
                  carry_q <= c_in;
`endif
                  idx_q   <= '0;
                  work_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               work_q  <= work_d;
               carry_q <= s_cout;
               if (idx_q == LAST_IDX) begin
                  // Outputs only ever see the completed result.
                  sum_q   <= work_d;
                  cout_q  <= s_cout;
`ifdef SEQ_ADD_SUB_EN
                  ovf_q   <= c_top ^ s_cout;
`endif
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  idx_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign c_out = cout_q;

endmodule
